// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the display encoder and scan decoder.
// Segment order is {a,b,c,d,e,f,g}; both segments and digit selects are active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [2:0] SEL_U    = 3'b110;
    localparam logic [2:0] SEL_D    = 3'b101;
    localparam logic [2:0] SEL_C    = 3'b011;
    localparam logic [2:0] SEL_NONE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GOT_U = 2'd1,
        ST_GOT_D = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD digit decoder.
// Any pattern outside the 0-9 table is flagged invalid.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);

    // Table lookup; unknown patterns fall to the default
    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        unique case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of a multiplexed 3-digit 7-segment display: sync, settle
// filter, U->D->C frame assembly, BCD to binary and stale-frame timeout.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int FREQ_CLK       = 50000000,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = FREQ_CLK / 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [2:0]  digit_sel_in,
    output logic [7:0]  value,
    output logic [11:0] bcd_out,
    output logic        value_valid,
    output logic        frame_err,
    output logic        stale
);

    localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [SW-1:0] STAB_MAX = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_PRE = SW'(SETTLE_CYCLES - 2);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_PRE   = TW'(TIMEOUT_CYCLES - 2);

    logic [6:0]    seg_s1, seg_s2, prev_seg;
    logic [2:0]    sel_s1, sel_s2, prev_sel;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] to_cnt;
    state_t        state;
    logic [3:0]    u_dig, d_dig;

    logic          same;
    logic          cap;
    logic          sel_ok;
    logic [3:0]    dec_digit;
    logic          dec_valid;
    logic [9:0]    bin;
    logic          frame_ok;
    logic          good_frame;

    seg7_to_bcd u_dec (
        .seg   (seg_s2),
        .digit (dec_digit),
        .valid (dec_valid)
    );

    // Two-stage synchronizer; idles at all ones (blank display)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_s1 <= SEG_BLANK;
            seg_s2 <= SEG_BLANK;
            sel_s1 <= SEL_NONE;
            sel_s2 <= SEL_NONE;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            sel_s1 <= digit_sel_in;
            sel_s2 <= sel_s1;
        end
    end

    assign same = ({sel_s2, seg_s2} == {prev_sel, prev_seg});
    // Capture exactly once, on the step that reaches STAB_MAX
    assign cap  = same && (stab_cnt == STAB_PRE);

    assign sel_ok = (sel_s2 == SEL_U) || (sel_s2 == SEL_D) ||
                    (sel_s2 == SEL_C);

    // Stability counter over the synced {sel,seg} word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_seg <= SEG_BLANK;
            prev_sel <= SEL_NONE;
            stab_cnt <= '0;
        end else begin
            prev_seg <= seg_s2;
            prev_sel <= sel_s2;
            if (!same)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // Hundreds digit comes straight from the decoder on the C capture
    assign bin = 10'(dec_digit) * 10'd100 +
                 10'(d_dig) * 10'd10 + 10'(u_dig);
    assign frame_ok = (dec_digit <= 4'd2) && (bin <= 10'd255);

    assign good_frame = cap && sel_ok && dec_valid &&
                        (state == ST_GOT_D) && (sel_s2 == SEL_C) &&
                        frame_ok;

    // Frame assembly FSM with registered value/pulse outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            u_dig       <= 4'd0;
            d_dig       <= 4'd0;
            value       <= 8'd0;
            bcd_out     <= 12'd0;
            value_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (cap && sel_ok) begin
                if (!dec_valid) begin
                    frame_err <= 1'b1;
                    state     <= ST_IDLE;
                end else begin
                    unique case (state)
                        ST_IDLE: begin
                            if (sel_s2 == SEL_U) begin
                                u_dig <= dec_digit;
                                state <= ST_GOT_U;
                            end
                        end
                        ST_GOT_U: begin
                            if (sel_s2 == SEL_U) begin
                                u_dig <= dec_digit;
                            end else if (sel_s2 == SEL_D) begin
                                d_dig <= dec_digit;
                                state <= ST_GOT_D;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= ST_IDLE;
                            end
                        end
                        ST_GOT_D: begin
                            if (sel_s2 == SEL_C) begin
                                state <= ST_IDLE;
                                if (frame_ok) begin
                                    value       <= bin[7:0];
                                    bcd_out     <= {dec_digit, d_dig, u_dig};
                                    value_valid <= 1'b1;
                                end else begin
                                    frame_err <= 1'b1;
                                end
                            end else if (sel_s2 == SEL_D) begin
                                d_dig <= dec_digit;
                            end else begin
                                frame_err <= 1'b1;
                                u_dig     <= dec_digit;
                                state     <= ST_GOT_U;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    // Stale timer: restarts with each good frame, saturates at the limit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            stale  <= 1'b1;
        end else if (good_frame) begin
            to_cnt <= '0;
            stale  <= 1'b0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TO_PRE)
                stale <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with SETTLE_CYCLES=4, TIMEOUT_CYCLES=200.
// Expected values are hand-computed from the digit patterns driven.
module tb_seg7_scan_decoder;
    import seg7_pkg::*;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_in;
    logic [2:0]  digit_sel_in;
    logic [7:0]  value;
    logic [11:0] bcd_out;
    logic        value_valid;
    logic        frame_err;
    logic        stale;

    int vectors;
    int errs;
    int vv_cnt;
    int fe_cnt;
    int both_cnt;
    int vv0;
    int fe0;

    seg7_scan_decoder #(
        .FREQ_CLK       (50000000),
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .seg_in       (seg_in),
        .digit_sel_in (digit_sel_in),
        .value        (value),
        .bcd_out      (bcd_out),
        .value_valid  (value_valid),
        .frame_err    (frame_err),
        .stale        (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (value_valid) vv_cnt++;
        if (frame_err) fe_cnt++;
        if (value_valid && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic show(input logic [2:0] sel, input logic [6:0] seg,
                        input int n);
        @(negedge clk);
        digit_sel_in = sel;
        seg_in       = seg;
        repeat (n) @(posedge clk);
    endtask

    task automatic mark();
        vv0 = vv_cnt;
        fe0 = fe_cnt;
    endtask

    initial begin
        vectors      = 0;
        errs         = 0;
        vv_cnt       = 0;
        fe_cnt       = 0;
        both_cnt     = 0;
        rst          = 1'b0;
        seg_in       = SEG_BLANK;
        digit_sel_in = SEL_NONE;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'h000);
        chk("rst_vv", 32'(value_valid), 32'd0);
        chk("rst_fe", 32'(frame_err), 32'd0);
        chk("rst_stale", 32'(stale), 32'd1);
        chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b1;
        show(SEL_NONE, SEG_BLANK, 10);

        // 1: good frame 125
        mark();
        show(SEL_U, SEG_5, 10);
        show(SEL_D, SEG_2, 10);
        show(SEL_C, SEG_1, 10);
        show(SEL_NONE, SEG_BLANK, 10);
        #1;
        chk("t1_value", 32'(value), 32'd125);
        chk("t1_bcd", 32'(bcd_out), 32'h125);
        chk("t1_vv_pulses", 32'(vv_cnt - vv0), 32'd1);
        chk("t1_fe_pulses", 32'(fe_cnt - fe0), 32'd0);
        chk("t1_stale", 32'(stale), 32'd0);

        // 2: short glitch on units select
        mark();
        show(SEL_U, SEG_5, 3);
        show(SEL_NONE, SEG_BLANK, 10);
        #1;
        chk("t2_state", 32'(dut.state), 32'(ST_IDLE));
        chk("t2_vv_pulses", 32'(vv_cnt - vv0), 32'd0);
        chk("t2_fe_pulses", 32'(fe_cnt - fe0), 32'd0);

        // 3: units then hundreds, tens skipped
        mark();
        show(SEL_U, SEG_5, 10);
        show(SEL_C, SEG_1, 10);
        show(SEL_NONE, SEG_BLANK, 10);
        #1;
        chk("t3_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
        chk("t3_vv_pulses", 32'(vv_cnt - vv0), 32'd0);
        chk("t3_value", 32'(value), 32'd125);

        // 4: invalid tens pattern
        mark();
        show(SEL_U, SEG_5, 10);
        show(SEL_D, 7'b1111110, 10);
        show(SEL_NONE, SEG_BLANK, 10);
        #1;
        chk("t4_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
        chk("t4_state", 32'(dut.state), 32'(ST_IDLE));

        // 5: 300 is out of range
        mark();
        show(SEL_U, SEG_0, 10);
        show(SEL_D, SEG_0, 10);
        show(SEL_C, SEG_3, 10);
        show(SEL_NONE, SEG_BLANK, 10);
        #1;
        chk("t5_fe_pulses", 32'(fe_cnt - fe0), 32'd1);
        chk("t5_vv_pulses", 32'(vv_cnt - vv0), 32'd0);
        chk("t5_value", 32'(value), 32'd125);
        chk("t5_bcd", 32'(bcd_out), 32'h125);

        // 6a: good frame 249, then idle into stale
        mark();
        show(SEL_U, SEG_9, 10);
        show(SEL_D, SEG_4, 10);
        show(SEL_C, SEG_2, 10);
        show(SEL_NONE, SEG_BLANK, 10);
        #1;
        chk("t6_value", 32'(value), 32'd249);
        chk("t6_bcd", 32'(bcd_out), 32'h249);
        chk("t6_vv_pulses", 32'(vv_cnt - vv0), 32'd1);
        chk("t6_stale_fresh", 32'(stale), 32'd0);
        repeat (200) @(posedge clk);
        #1;
        chk("t6_stale_timeout", 32'(stale), 32'd1);

        // 6b: reset after U,D discards the partial frame
        show(SEL_U, SEG_1, 10);
        show(SEL_D, SEG_2, 10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6r_value", 32'(value), 32'd0);
        chk("t6r_bcd", 32'(bcd_out), 32'h000);
        chk("t6r_stale", 32'(stale), 32'd1);
        chk("t6r_state", 32'(dut.state), 32'(ST_IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        mark();
        show(SEL_C, SEG_1, 10);
        show(SEL_NONE, SEG_BLANK, 10);
        #1;
        chk("t6r_vv_pulses", 32'(vv_cnt - vv0), 32'd0);
        chk("t6r_fe_pulses", 32'(fe_cnt - fe0), 32'd0);
        chk("t6r_value_hold", 32'(value), 32'd0);

        chk("vv_fe_overlap", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
